motoro3_deadtime: RTL and testbench
===================================

Name: motoro3_deadtime

Overview:
- Sits directly downstream of the 3-phase gate-drive top. Consumes its six registered gate signals (per phase: high-side active-high, low-side active-low) and drives the MOSFET pins.
- Per phase, inserts a programmable dead time whenever a conductor turns off.
- Blocks shoot-through: any phase requesting high and low simultaneously is a conflict.
- Latches a sticky fault that forces all bridges off until cleared.

Parameters:
- DEAD_CYC, 20, minimum both-off gap in clkI cycles (2 us at 10 MHz); legal range 1..255.
- CNT_W, 8, width of the dead-time counter and of the fault counter.
- LOW_ACT_LOW, 1, 1 = low-side pins active-low on both input and output; 0 = active-high.

Ports:
- clkI  in  1  system clock, 10 MHz.
- rstI  in  1  asynchronous active-high reset.
- aHPi  in  1  phase A high-side request, active-high.
- aLNi  in  1  phase A low-side request, polarity per LOW_ACT_LOW.
- bHPi  in  1  phase B high-side request, active-high.
- bLNi  in  1  phase B low-side request, polarity per LOW_ACT_LOW.
- cHPi  in  1  phase C high-side request, active-high.
- cLNi  in  1  phase C low-side request, polarity per LOW_ACT_LOW.
- enI  in  1  global enable; 0 forces all phases off.
- clrFaultI  in  1  single-cycle fault clear.
- aHPo  out  1  phase A high-side gate.
- aLNo  out  1  phase A low-side gate.
- bHPo  out  1  phase B high-side gate.
- bLNo  out  1  phase B low-side gate.
- cHPo  out  1  phase C high-side gate.
- cLNo  out  1  phase C low-side gate.
- faultO  out  1  sticky shoot-through fault.
- faultCntO  out  CNT_W  saturating count of conflict cycles.
- deadBusyO  out  3  per-phase dead-gap active (bit0 = A, bit1 = B, bit2 = C).

Behaviour:
- One clock (clkI). Reset rstI is asynchronous, active-high.
- Reset values:
  - all high-side outputs 0;
  - low-side outputs at the off level (1 when LOW_ACT_LOW = 1);
  - faultO = 0, faultCntO = 0, deadBusyO = 3'b111;
  - every phase in state OFF with cnt = DEAD_CYC-1.
- Request decode per phase (combinational, inputs already registered upstream):
  - reqH = xHPi.
  - reqL = xLNi ^ LOW_ACT_LOW.
  - conflict = reqH & reqL.
  - A conflict is treated as "no request".
- Per-phase FSM, all outputs registered:
  - OFF:
    - If cnt != 0: cnt <= cnt-1; deadBusy = 1.
    - If cnt == 0 and allowed and exactly one request: go to H_ON or L_ON and drive that gate at this edge.
    - allowed = enI & ~faultO.
  - H_ON / L_ON:
    - Remain while the same single request persists and allowed.
    - Otherwise, at this edge: gate off, go to OFF, cnt <= DEAD_CYC-1.
    - This includes: request dropped, request flipped to the other side, conflict, enI low, or fault set.
  - Resulting gap: both gates off for exactly DEAD_CYC cycles minimum between any turn-off and the next turn-on.
  - Direct H_ON <-> L_ON transitions do not exist.
  - After reset release, the earliest turn-on is at rising edge number DEAD_CYC.
- Latency with no dead-gap pending: request to output is 1 cycle.
- Fault:
  - Any phase conflict in a cycle sets faultO at that edge.
  - faultCntO increments by 1 per conflict cycle (not per phase) and saturates at all-ones.
  - While faultO = 1, all phases turn off at the next edge and stay OFF. Counters still run.
- Fault clear:
  - clrFaultI = 1 with no conflict that cycle: faultO <= 0 and faultCntO is unchanged.
  - clrFaultI and a conflict in the same cycle: faultO stays 1 and the count increments.
  - faultCntO is cleared only by reset.
- A phase cannot turn on until both of the following hold:
  - its dead gap has expired, and
  - the cycle after faultO deasserts.
- enI deasserted: same turn-off path as a dropped request. No fault is raised.
- Reset mid-operation: outputs go off immediately (asynchronously); the full DEAD_CYC gap applies again after release.
- Phases are fully independent except for the shared fault and enI.

Test Plan:
1. DEAD_CYC = 4, enI = 1, hold aHPi = 1 from reset release. Required: aHPo rises at edge 4, deadBusyO[0] falls at the same edge. Other phases stay off (LNo = 1).
2. Phase A in H_ON; at edge t switch to aHPi = 0, aLNi = 0. Required: aHPo = 0 at t+1. aLNo = 1 for edges t+1..t+4. aLNo = 0 at t+5.
3. Assert bHPi = 1 and bLNi = 0 together (conflict) while A and C are conducting. Required: faultO = 1 and faultCntO = 1 next edge. All six outputs off the edge after. Nothing turns on while faultO = 1.
4. Hold the conflict for 300 cycles with CNT_W = 8. Required: faultCntO saturates at 255. clrFaultI during the conflict leaves faultO = 1.
5. Remove the conflict, pulse clrFaultI with cHPi = 1 held. Required: faultO = 0 next edge. cHPo turns on only after the C dead gap has expired and faultO = 0. faultCntO is retained.
6. Phase in L_ON, drop enI for 2 cycles, then restore. Required: gate off 1 cycle after the drop. Re-on no earlier than DEAD_CYC cycles after turn-off. faultO stays 0.
7. Assert rstI asynchronously mid-H_ON. Required: outputs off without waiting for a clock edge. After release, DEAD_CYC edges elapse before the gate turns on again.

Source files
------------

// File: rtl/motoro3_deadtime_if.sv
// Gate-drive bundle between the 3-phase gate-drive top, the dead-time stage
// and the MOSFET pins.
//   master : upstream side. Drives the per-phase requests (xHPi high-side
//            active-high, xLNi low-side), enI and clrFaultI, and observes the
//            gate pins and status.
//   slave  : dead-time stage. Consumes the requests and drives the gate pins
//            (xHPo, xLNo), faultO, faultCntO and deadBusyO.
interface motoro3_deadtime_if #(
  parameter int CNT_W = 8
);
  logic             aHPi;
  logic             aLNi;
  logic             bHPi;
  logic             bLNi;
  logic             cHPi;
  logic             cLNi;
  logic             enI;
  logic             clrFaultI;
  logic             aHPo;
  logic             aLNo;
  logic             bHPo;
  logic             bLNo;
  logic             cHPo;
  logic             cLNo;
  logic             faultO;
  logic [CNT_W-1:0] faultCntO;
  logic [2:0]       deadBusyO;

  modport master (
    output aHPi, aLNi, bHPi, bLNi, cHPi, cLNi, enI, clrFaultI,
    input  aHPo, aLNo, bHPo, bLNo, cHPo, cLNo, faultO, faultCntO, deadBusyO
  );

  modport slave (
    input  aHPi, aLNi, bHPi, bLNi, cHPi, cLNi, enI, clrFaultI,
    output aHPo, aLNo, bHPo, bLNo, cHPo, cLNo, faultO, faultCntO, deadBusyO
  );
endinterface

// File: rtl/motoro3_deadtime.sv
// Dead-time inserter and shoot-through guard for a 3-phase bridge.
// Each phase runs an OFF / H_ON / L_ON FSM. Every turn-off reloads a gap
// counter, so both gates stay off for at least DEAD_CYC cycles before either
// one turns on again. A phase requesting both sides at once is a conflict:
// it is treated as no request and latches a sticky fault that turns every
// bridge off until clrFaultI is applied in a conflict-free cycle.
// Ports:
//   clkI : system clock
//   rstI : asynchronous active-high reset (all gates off, full gap rearmed)
//   io   : slave side of motoro3_deadtime_if (requests, enable, fault clear
//          in; gate pins, faultO, faultCntO, deadBusyO out)
module motoro3_deadtime #(
  parameter int DEAD_CYC    = 20,
  parameter int CNT_W       = 8,
  parameter bit LOW_ACT_LOW = 1'b1
) (
  input logic                clkI,
  input logic                rstI,
  motoro3_deadtime_if.slave  io
);

  typedef enum logic [1:0] {OFF, H_ON, L_ON} phase_t;

  localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic [2:0]       req_h;
  logic [2:0]       req_l;
  logic [2:0]       conflict;
  logic             conflict_any;
  logic             allowed;
  logic [2:0]       gate_h;
  logic [2:0]       gate_l;
  logic [2:0]       busy;
  logic             fault;
  logic             fault_n;
  logic [CNT_W-1:0] fcnt;
  logic [CNT_W-1:0] fcnt_n;

  assign req_h        = {io.cHPi, io.bHPi, io.aHPi};
  assign req_l        = {io.cLNi, io.bLNi, io.aLNi} ^ {3{LOW_ACT_LOW}};
  assign conflict     = req_h & req_l;
  assign conflict_any = |conflict;
  // Uses the registered fault, so a new fault turns phases off one edge
  // after it is raised and a cleared fault allows turn-on one edge later.
  assign allowed      = io.enI & ~fault;

  for (genvar p = 0; p < 3; p++) begin : g_phase
    phase_t           state;
    phase_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             gh;
    logic             gl;
    logic             bz;
    logic             gh_n;
    logic             gl_n;
    logic             bz_n;

    always_comb begin
      state_n = state;
      cnt_n   = cnt;
      gh_n    = 1'b0;
      gl_n    = 1'b0;
      bz_n    = 1'b0;
      case (state)
        OFF: begin
          if (cnt != '0) begin
            cnt_n = cnt - ONE;
            bz_n  = 1'b1;
          end else if (allowed && (req_h[p] ^ req_l[p])) begin
            // A conflict has both requests set, so the XOR rejects it.
            if (req_h[p]) begin
              state_n = H_ON;
              gh_n    = 1'b1;
            end else begin
              state_n = L_ON;
              gl_n    = 1'b1;
            end
          end
        end
        H_ON: begin
          if (allowed && req_h[p] && !req_l[p]) begin
            gh_n = 1'b1;
          end else begin
            state_n = OFF;
            cnt_n   = DEAD_LOAD;
            bz_n    = 1'b1;
          end
        end
        L_ON: begin
          if (allowed && req_l[p] && !req_h[p]) begin
            gl_n = 1'b1;
          end else begin
            state_n = OFF;
            cnt_n   = DEAD_LOAD;
            bz_n    = 1'b1;
          end
        end
        default: begin
          state_n = OFF;
          cnt_n   = DEAD_LOAD;
          bz_n    = 1'b1;
        end
      endcase
    end

    always_ff @(posedge clkI or posedge rstI) begin
      if (rstI) begin
        state <= OFF;
        cnt   <= DEAD_LOAD;
        gh    <= 1'b0;
        gl    <= 1'b0;
        bz    <= 1'b1;
      end else begin
        state <= state_n;
        cnt   <= cnt_n;
        gh    <= gh_n;
        gl    <= gl_n;
        bz    <= bz_n;
      end
    end

    assign gate_h[p] = gh;
    assign gate_l[p] = gl;
    assign busy[p]   = bz;
  end

  always_comb begin
    fault_n = fault;
    fcnt_n  = fcnt;
    if (conflict_any) begin
      // A conflict outranks a simultaneous clear.
      fault_n = 1'b1;
      if (fcnt != '1) begin
        fcnt_n = fcnt + ONE;
      end
    end else if (io.clrFaultI) begin
      fault_n = 1'b0;
    end
  end

  always_ff @(posedge clkI or posedge rstI) begin
    if (rstI) begin
      fault <= 1'b0;
      fcnt  <= '0;
    end else begin
      fault <= fault_n;
      fcnt  <= fcnt_n;
    end
  end

  // Gate state is held active-high internally; XOR with a constant keeps the
  // low-side pins glitch-free at their configured polarity.
  assign io.aHPo      = gate_h[0];
  assign io.bHPo      = gate_h[1];
  assign io.cHPo      = gate_h[2];
  assign io.aLNo      = gate_l[0] ^ LOW_ACT_LOW;
  assign io.bLNo      = gate_l[1] ^ LOW_ACT_LOW;
  assign io.cLNo      = gate_l[2] ^ LOW_ACT_LOW;
  assign io.faultO    = fault;
  assign io.faultCntO = fcnt;
  assign io.deadBusyO = busy;

endmodule

// File: tb/tb_motoro3_deadtime.sv
// Scoreboard bench for motoro3_deadtime with DEAD_CYC = 4, CNT_W = 8 and
// active-low low-side pins. Stimulus pushes hand-computed expectations,
// each tagged with the rising-edge number after which it must hold. Edges
// are counted from the most recent reset release. A negedge monitor pops
// and compares them.
// Observed vector layout: {faultO, faultCntO[7:0], deadBusyO[2:0],
//                          aHPo, aLNo, bHPo, bLNo, cHPo, cLNo}.
module tb_motoro3_deadtime;

  localparam int DEAD_CYC = 4;
  localparam int CNT_W    = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   edge_cnt = 0;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  motoro3_deadtime_if #(.CNT_W(CNT_W)) bus ();

  motoro3_deadtime #(
    .DEAD_CYC   (DEAD_CYC),
    .CNT_W      (CNT_W),
    .LOW_ACT_LOW(1'b1)
  ) dut (
    .clkI(clk),
    .rstI(rst),
    .io  (bus.slave)
  );

  typedef struct {
    int          cyc;
    string       name;
    logic [17:0] val;
    logic [17:0] mask;
  } exp_t;

  exp_t sb[$];

  always @(posedge clk or posedge rst) begin
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  function automatic logic [17:0] observe();
    return {bus.faultO, bus.faultCntO, bus.deadBusyO,
            bus.aHPo, bus.aLNo, bus.bHPo, bus.bLNo, bus.cHPo, bus.cLNo};
  endfunction

  function automatic void push_exp(int cyc, string name, logic [17:0] val, logic [17:0] mask);
    exp_t e;
    e.cyc  = cyc;
    e.name = name;
    e.val  = val;
    e.mask = mask;
    sb.push_back(e);
  endfunction

  // Gate order: {aH, aL, bH, bL, cH, cL}; all off is 6'b010101.
  function automatic void exp_gates(int cyc, string name, logic [5:0] g);
    push_exp(cyc, name, {12'b0, g}, 18'h0003F);
  endfunction

  function automatic void exp_busy(int cyc, string name, logic [2:0] b);
    push_exp(cyc, name, {9'b0, b, 6'b0}, 18'h001C0);
  endfunction

  function automatic void exp_fcnt(int cyc, string name, logic [7:0] c);
    push_exp(cyc, name, {1'b0, c, 9'b0}, 18'h1FE00);
  endfunction

  function automatic void exp_fault(int cyc, string name, logic f);
    push_exp(cyc, name, {f, 17'b0}, 18'h20000);
  endfunction

  // Monitor: compare every expectation due at this edge; anything whose edge
  // has already gone by is reported as missed.
  always @(negedge clk) begin
    logic [17:0] obs;
    obs = observe();
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == edge_cnt) begin
        checks++;
        if ((obs & sb[i].mask) === (sb[i].val & sb[i].mask)) begin
          passed++;
        end else begin
          $display("FAIL %s @edge %0d: got %h, want %h (mask %h)",
                   sb[i].name, edge_cnt, obs & sb[i].mask, sb[i].val & sb[i].mask, sb[i].mask);
        end
        sb.delete(i);
      end else if (sb[i].cyc < edge_cnt) begin
        checks++;
        $display("FAIL %s: expected at edge %0d, now edge %0d, never compared",
                 sb[i].name, sb[i].cyc, edge_cnt);
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic to_edge(int n);
    while (edge_cnt < n) tick();
  endtask

  initial begin
    #20000;
    checks++;
    $display("FAIL watchdog: time %0t, edge %0d, scoreboard depth %0d", $time, edge_cnt, sb.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    bus.aHPi      = 1'b0;
    bus.aLNi      = 1'b1;
    bus.bHPi      = 1'b0;
    bus.bLNi      = 1'b1;
    bus.cHPi      = 1'b0;
    bus.cLNi      = 1'b1;
    bus.enI       = 1'b1;
    bus.clrFaultI = 1'b0;

    #1 rst = 1'b1;
    exp_gates(0, "reset_gates", 6'b010101);
    exp_busy (0, "reset_busy",  3'b111);
    exp_fault(0, "reset_fault", 1'b0);
    exp_fcnt (0, "reset_fcnt",  8'd0);

    // Phase A requests high from before reset release.
    bus.aHPi = 1'b1;
    repeat (2) tick();
    rst = 1'b0;

    exp_gates(3, "t1_gap_still_off", 6'b010101);
    exp_busy (3, "t1_busy_in_gap",   3'b111);
    exp_gates(4, "t1_a_high_on",     6'b110101);
    exp_busy (4, "t1_busy_clear",    3'b000);

    // A flips to low-side, C requests high-side.
    to_edge(6);
    bus.aHPi = 1'b0;
    bus.aLNi = 1'b0;
    bus.cHPi = 1'b1;
    exp_gates(7,  "t2_a_off_c_on",  6'b010111);
    exp_busy (7,  "t2_busy_a_gap",  3'b001);
    exp_gates(10, "t2_a_gap_last",  6'b010111);
    exp_busy (10, "t2_busy_a_last", 3'b001);
    exp_gates(11, "t2_a_low_on",    6'b000111);
    exp_busy (11, "t2_busy_done",   3'b000);

    // Enable dropped for two cycles.
    to_edge(13);
    bus.enI = 1'b0;
    exp_gates(14, "t6_en_off",      6'b010101);
    exp_busy (14, "t6_busy_ac",     3'b101);
    exp_fault(14, "t6_no_fault",    1'b0);
    to_edge(15);
    bus.enI = 1'b1;
    exp_gates(17, "t6_gap_last",    6'b010101);
    exp_gates(18, "t6_reon",        6'b000111);
    exp_fault(18, "t6_no_fault_on", 1'b0);

    // Conflict on B while A (low) and C (high) conduct.
    to_edge(20);
    bus.bHPi = 1'b1;
    bus.bLNi = 1'b0;
    exp_gates(21,  "t3_on_at_fault_edge", 6'b000111);
    exp_fault(21,  "t3_fault_set",        1'b1);
    exp_fcnt (21,  "t3_fcnt_1",           8'd1);
    exp_gates(22,  "t3_all_off",          6'b010101);
    exp_busy (22,  "t3_busy_ac",          3'b101);
    exp_fcnt (22,  "t3_fcnt_2",           8'd2);
    exp_gates(100, "t4_held_off",         6'b010101);
    exp_fcnt (274, "t4_fcnt_254",         8'd254);
    exp_fcnt (275, "t4_fcnt_sat",         8'd255);

    to_edge(290);
    bus.clrFaultI = 1'b1;
    exp_fault(291, "t4_clr_during_conflict", 1'b1);
    exp_fcnt (291, "t4_fcnt_still_sat",      8'd255);
    to_edge(291);
    bus.clrFaultI = 1'b0;
    exp_fcnt (300, "t4_fcnt_sat_held",       8'd255);

    // Conflict removed; fault stays until cleared.
    to_edge(320);
    bus.bHPi = 1'b0;
    bus.bLNi = 1'b1;
    exp_fault(321, "t5_sticky",      1'b1);
    exp_fcnt (321, "t5_fcnt_frozen", 8'd255);
    to_edge(322);
    bus.clrFaultI = 1'b1;
    exp_fault(323, "t5_cleared",     1'b0);
    exp_fcnt (323, "t5_fcnt_kept",   8'd255);
    exp_gates(323, "t5_off_at_clear", 6'b010101);
    to_edge(323);
    bus.clrFaultI = 1'b0;
    exp_gates(324, "t5_c_a_on",      6'b000111);
    exp_fcnt (324, "t5_fcnt_kept2",  8'd255);

    // Asynchronous reset while conducting.
    to_edge(330);
    exp_gates(330, "t7_pre_reset", 6'b000111);
    @(negedge clk);
    #1;
    tick();
    rst = 1'b1;
    exp_gates(0, "t7_async_off",  6'b010101);
    exp_busy (0, "t7_async_busy", 3'b111);
    exp_fcnt (0, "t7_async_fcnt", 8'd0);
    @(negedge clk);
    #1;
    tick();
    rst = 1'b0;
    exp_gates(3, "t7_gap_last", 6'b010101);
    exp_gates(4, "t7_reon",     6'b000111);

    to_edge(6);
    @(negedge clk);
    #1;
    while (sb.size() != 0) begin
      checks++;
      $display("FAIL %s: expected at edge %0d, left unchecked", sb[0].name, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
